// File: rtl/norm_pkg.sv
// Shared types and helpers for the adder-result normalization controller.
// Holds the controller state encoding, the default per-cycle shift limit and a 3-way minimum.
package norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_STEP = 8;

    function automatic int unsigned min3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage

// File: rtl/norm_sequencer_find_first_one.sv
// Leading-one locator: reports the index of the highest set bit of i_vec.
// o_valid is low when the vector is all zeros.
module FindFirstOne #(
    parameter  int N     = 25,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_vec,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_index
);

    // Ascending scan so the highest set bit is the last one to write o_index.
    always_comb begin
        o_valid = 1'b0;
        o_index = '0;
        for (int i = 0; i < N; i++) begin
            if (i_vec[i]) begin
                o_valid = 1'b1;
                o_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/norm_sequencer.sv
// Multi-cycle normalizer: shifts the magnitude left by at most STEP bits per cycle
// until its MSB is set or the exponent reaches zero, with valid/ready on both sides.
module norm_sequencer
    import norm_pkg::*;
#(
    parameter  int N     = 25,
    parameter  int E     = 8,
    parameter  int STEP  = DEFAULT_STEP,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [E-1:0]     in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic [E-1:0]     out_exp,
    output logic [IDX_W-1:0] out_shift,
    output logic             out_zero,
    output logic             out_subnorm,
    output logic             busy
);

    localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(N - 1);

    state_t r_state;
    state_t w_nextState;

    logic [N-1:0]     r_data;
    logic [E-1:0]     r_exp;
    logic [IDX_W-1:0] r_shift;
    logic             r_zero;
    logic             r_subnorm;

    logic             w_ffoValid;
    logic [IDX_W-1:0] w_ffoIndex;
    logic [IDX_W-1:0] w_lead;
    logic [31:0]      w_amtFull;
    logic [31:0]      w_limitFull;
    logic [IDX_W-1:0] w_amtIdx;
    logic [E-1:0]     w_amtExp;
    logic             w_final;
    logic             w_subnormStep;
    logic             w_accept;
    logic             w_release;

    FindFirstOne #(
        .N (N)
    ) u_findFirstOne (
        .i_vec   (r_data),
        .o_valid (w_ffoValid),
        .o_index (w_ffoIndex)
    );

    // Per-cycle shift amount; the operand is finished once the shift is no longer
    // limited by STEP, i.e. it covers the whole remaining distance or exponent.
    always_comb begin
        w_lead        = MSB_IDX - w_ffoIndex;
        w_limitFull   = (32'(w_lead) < 32'(r_exp)) ? 32'(w_lead) : 32'(r_exp);
        w_amtFull     = min3(32'(w_lead), 32'(STEP), 32'(r_exp));
        w_final       = (w_amtFull == w_limitFull);
        w_subnormStep = w_final && (32'(w_lead) > 32'(r_exp));
        w_amtIdx      = IDX_W'(w_amtFull);
        w_amtExp      = E'(w_amtFull);
        w_accept      = (r_state == IDLE) && in_valid;
        w_release     = (r_state == DONE) && out_ready;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = SCAN;
            SCAN:    if (!w_ffoValid || w_final) w_nextState = DONE;
            DONE:    if (w_release) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // The working registers double as the result registers, so a finished result
    // stays visible in IDLE until the next operand is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_data    <= '0;
            r_exp     <= '0;
            r_shift   <= '0;
            r_zero    <= 1'b0;
            r_subnorm <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data    <= in_data;
                        r_exp     <= in_exp;
                        r_shift   <= '0;
                        r_zero    <= 1'b0;
                        r_subnorm <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!w_ffoValid) begin
                        r_zero  <= 1'b1;
                        r_data  <= '0;
                        r_exp   <= '0;
                        r_shift <= '0;
                    end else begin
                        r_data  <= r_data << w_amtIdx;
                        r_exp   <= r_exp - w_amtExp;
                        r_shift <= r_shift + w_amtIdx;
                        if (w_final) begin
                            r_subnorm <= w_subnormStep;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready    = (r_state == IDLE) && !reset;
        out_valid   = (r_state == DONE);
        busy        = (r_state != IDLE);
        out_data    = r_data;
        out_exp     = r_exp;
        out_shift   = r_shift;
        out_zero    = r_zero;
        out_subnorm = r_subnorm;
    end

endmodule

// File: tb/tb_norm_sequencer.sv
// Self-checking bench for norm_sequencer: directed cases, hold/reset scenarios and a
// randomized sweep compared against a behavioural normalization model.
module tb_norm_sequencer;

    localparam int N     = 25;
    localparam int E     = 8;
    localparam int STEP  = 8;
    localparam int IDX_W = $clog2(N);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [N-1:0]     in_data = '0;
    logic [E-1:0]     in_exp = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [N-1:0]     out_data;
    logic [E-1:0]     out_exp;
    logic [IDX_W-1:0] out_shift;
    logic             out_zero;
    logic             out_subnorm;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] data;
        logic [E-1:0] exp;
        int           shift;
        bit           zero;
        bit           subnorm;
        int           cycles;
    } result_t;

    norm_sequencer #(
        .N    (N),
        .E    (E),
        .STEP (STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_exp      (in_exp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_exp     (out_exp),
        .out_shift   (out_shift),
        .out_zero    (out_zero),
        .out_subnorm (out_subnorm),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Normalize in one step: total shift is the smaller of the leading-zero count
    // and the exponent; the controller spends ceil(shift/STEP) cycles (at least 1).
    function automatic result_t refModel(input logic [N-1:0] d, input logic [E-1:0] e);
        result_t r;
        int msb;
        int lead;
        int s;
        r.zero    = 1'b0;
        r.subnorm = 1'b0;
        if (d == '0) begin
            r.zero   = 1'b1;
            r.data   = '0;
            r.exp    = '0;
            r.shift  = 0;
            r.cycles = 1;
        end else begin
            msb = 0;
            for (int i = 0; i < N; i++) if (d[i]) msb = i;
            lead      = N - 1 - msb;
            s         = (lead < int'(e)) ? lead : int'(e);
            r.data    = d << s;
            r.exp     = e - E'(s);
            r.shift   = s;
            r.subnorm = (lead > int'(e));
            r.cycles  = (s == 0) ? 1 : (s + STEP - 1) / STEP;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string name, input result_t m);
        checkOutput({name, ".out_data"},    64'(out_data),    64'(m.data));
        checkOutput({name, ".out_exp"},     64'(out_exp),     64'(m.exp));
        checkOutput({name, ".out_shift"},   64'(out_shift),   64'(m.shift));
        checkOutput({name, ".out_zero"},    64'(out_zero),    64'(m.zero));
        checkOutput({name, ".out_subnorm"}, 64'(out_subnorm), 64'(m.subnorm));
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, ".out_valid"},   64'(out_valid),   64'd0);
        checkOutput({name, ".out_data"},    64'(out_data),    64'd0);
        checkOutput({name, ".out_exp"},     64'(out_exp),     64'd0);
        checkOutput({name, ".out_shift"},   64'(out_shift),   64'd0);
        checkOutput({name, ".out_zero"},    64'(out_zero),    64'd0);
        checkOutput({name, ".out_subnorm"}, 64'(out_subnorm), 64'd0);
        checkOutput({name, ".busy"},        64'(busy),        64'd0);
        checkOutput({name, ".in_ready"},    64'(in_ready),    64'd0);
    endtask

    // One full transaction: accept, wait for the result, optionally stall the
    // consumer while poking in_valid, then complete the output handshake.
    task automatic applyStimulus(input string name, input logic [N-1:0] d, input logic [E-1:0] e,
                                 input int holdCycles);
        result_t m;
        int edges;
        m = refModel(d, e);
        edges = 0;
        while (!in_ready && edges < 50) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({name, ".in_ready"}, 64'(in_ready), 64'd1);
        in_data  = d;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = N'($urandom);
        in_exp   = E'($urandom);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput({name, ".latency"}, 64'(edges), 64'(m.cycles + 1));
        checkResult(name, m);
        checkOutput({name, ".busy"}, 64'(busy), 64'd1);
        for (int k = 0; k < holdCycles; k++) begin
            in_valid = 1'($urandom);
            in_data  = N'($urandom);
            in_exp   = E'($urandom);
            @(posedge clk); #1;
            checkOutput({name, ".hold.out_valid"}, 64'(out_valid), 64'd1);
            checkOutput({name, ".hold.in_ready"},  64'(in_ready),  64'd0);
            checkOutput({name, ".hold.out_data"},  64'(out_data),  64'(m.data));
            checkOutput({name, ".hold.out_exp"},   64'(out_exp),   64'(m.exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, ".after.out_valid"}, 64'(out_valid), 64'd0);
        checkOutput({name, ".after.in_ready"},  64'(in_ready),  64'd1);
        checkOutput({name, ".after.busy"},      64'(busy),      64'd0);
        checkOutput({name, ".after.out_data"},  64'(out_data),  64'(m.data));
    endtask

    initial begin
        logic [E-1:0] expSet [4];
        result_t m;
        expSet[0] = 8'd0;
        expSet[1] = 8'd1;
        expSet[2] = 8'(STEP);
        expSet[3] = 8'hFF;

        #2;
        reset = 1'b1;
        #3;
        checkResetState("reset");
        repeat (2) @(posedge clk);
        #1;
        checkResetState("resetHeld");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("release.in_ready", 64'(in_ready), 64'd1);

        $display("[TB] directed cases");
        applyStimulus("case1", 25'h1000000, 8'd100, 0);
        applyStimulus("case2", 25'h0000001, 8'd100, 0);
        applyStimulus("case3", 25'h0000000, 8'd50, 0);
        applyStimulus("case4", 25'h0000100, 8'd5, 0);
        applyStimulus("case5", 25'h0000001, 8'd100, 10);
        @(posedge clk); #1;
        checkOutput("case5.single.out_valid", 64'(out_valid), 64'd0);
        checkOutput("case5.single.busy",      64'(busy),      64'd0);

        $display("[TB] reset during scan");
        in_data  = 25'h0000001;
        in_exp   = 8'd100;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("case6.midScan.busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        checkResetState("case6.reset");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("case6.release.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        checkOutput("case6.idle.out_valid", 64'(out_valid), 64'd0);
        checkOutput("case6.idle.busy",      64'(busy),      64'd0);
        applyStimulus("case6.next", 25'h1000000, 8'd100, 0);

        $display("[TB] single-bit sweep");
        for (int b = 0; b < N; b++) begin
            for (int j = 0; j < 4; j++) begin
                applyStimulus($sformatf("sweep.b%0d.e%0d", b, expSet[j]),
                              N'(1) << b, expSet[j], 0);
            end
        end

        $display("[TB] random operands");
        for (int n = 0; n < 150; n++) begin
            logic [N-1:0] d;
            logic [E-1:0] e;
            d = N'($urandom) >> $urandom_range(0, N);
            e = ($urandom_range(0, 1) == 1) ? E'($urandom) : E'($urandom_range(0, 2 * STEP));
            applyStimulus($sformatf("rand%0d", n), d, e, $urandom_range(0, 2));
        end

        m = refModel(25'h0000001, 8'd100);
        checkOutput("model.sanity.shift", 64'(m.shift), 64'd24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
